// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the program ROM address, issues one instruction per cycle
// into ir with a valid/ready handshake, folds unconditional jumps (opcode 4'b1000) in fetch,
// and parks in a halted state on a self-jump until execute redirects it.
module fetch_unit #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned INST_W = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [INST_W-1:0] rom_instruction,
  output logic [INST_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0]   ir_q, ir_d;
  logic [ADDR_W-1:0]   ir_pc_q, ir_pc_d;
  logic                ir_valid_q, ir_valid_d;
  logic                halted_q, halted_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                advance;
  logic                is_jmp;
  logic [ADDR_W-1:0]   jmp_target;

  assign advance    = !ir_valid_q || ir_ready;
  assign is_jmp     = (rom_instruction[15:12] == 4'b1000);
  assign jmp_target = ADDR_W'(rom_instruction[11:8]);

  // Next-state: redirect beats stall, advance and folded jump; jumps never reach ir.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    halted_d   = halted_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (run) state_d = StRun;
      end
      StRun: begin
        if (redirect_valid) begin
          pc_d       = redirect_target;
          ir_valid_d = 1'b0;
          halted_d   = 1'b0;
        end else if (advance) begin
          if (is_jmp) begin
            pc_d       = jmp_target;
            ir_valid_d = 1'b0;
            if (jmp_target == pc_q) begin
              state_d  = StHalt;
              halted_d = 1'b1;
            end
          end else begin
            ir_d       = rom_instruction;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            pc_d       = pc_q + ADDR_W'(1);
            cnt_d      = cnt_q + CNT_W'(1);
          end
        end
      end
      StHalt: begin
        ir_valid_d = 1'b0;
        if (redirect_valid) begin
          pc_d     = redirect_target;
          state_d  = StRun;
          halted_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rom_address = pc_q;
  assign ir          = ir_q;
  assign ir_pc       = ir_pc_q;
  assign ir_valid    = ir_valid_q;
  assign halted      = halted_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational ROM model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [3:0]  rom_address;
  logic [15:0] rom_instruction;
  logic [15:0] ir;
  logic [3:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect_valid;
  logic [3:0]  redirect_target;
  logic        halted;
  logic [7:0]  fetch_count;

  logic [15:0] rom [16];
  int          checks = 0;
  int          errors = 0;

  assign rom_instruction = rom[rom_address];

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(4), .INST_W(16), .CNT_W(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .run             (run),
    .rom_address     (rom_address),
    .rom_instruction (rom_instruction),
    .ir              (ir),
    .ir_pc           (ir_pc),
    .ir_valid        (ir_valid),
    .ir_ready        (ir_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; ir_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    rom[0] = 16'hA601; rom[1] = 16'hB401; rom[2] = 16'h3681; rom[3] = 16'hF600;
    rom[4] = 16'h8200;
  endtask

  // Reset values and IDLE hold with run low.
  task automatic test_reset();
    do_reset();
    checks++;
    if ({ir, ir_pc, ir_valid, halted, fetch_count, rom_address} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ir=%h ir_pc=%0d v=%b h=%b cnt=%0d addr=%0d, required all 0",
               ir, ir_pc, ir_valid, halted, fetch_count, rom_address);
    end
    ir_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 4'd7;
    repeat (3) step();
    checks++;
    if (rom_address !== 4'd0 || ir_valid !== 1'b0 || fetch_count !== 8'd0) begin
      errors++;
      $display("FAIL idle_hold: addr=%0d v=%b cnt=%0d, required 0 0 0",
               rom_address, ir_valid, fetch_count);
    end
    redirect_valid = 1'b0;
  endtask

  // Program with folded jump back to 2: 0,1,2,3,bubble,2,3,bubble,2.
  task automatic test_sequence();
    logic       ev [9] = '{1, 1, 1, 1, 0, 1, 1, 0, 1};
    logic [3:0] ep [9] = '{0, 1, 2, 3, 3, 2, 3, 3, 2};
    logic [7:0] ec [9] = '{1, 2, 3, 4, 4, 5, 6, 6, 7};
    load_prog();
    do_reset();
    run = 1'b1; ir_ready = 1'b1;
    step();
    run = 1'b0;
    checks++;
    if (ir_valid !== 1'b0) begin
      errors++; $display("FAIL seq_first_cycle: ir_valid=%b, required 0", ir_valid);
    end
    for (int k = 0; k < 9; k++) begin
      step();
      checks++;
      if (ir_valid !== ev[k] || fetch_count !== ec[k] || (ev[k] && (ir_pc !== ep[k] ||
          ir !== rom[ep[k]]))) begin
        errors++;
        $display("FAIL seq_%0d: v=%b pc=%0d ir=%h cnt=%0d, required v=%b pc=%0d ir=%h cnt=%0d",
                 k, ir_valid, ir_pc, ir, fetch_count, ev[k], ep[k], rom[ep[k]], ec[k]);
      end
    end
  endtask

  // Three stall cycles while ir_pc=2, then resume with ir_pc=3.
  task automatic test_stall();
    load_prog();
    do_reset();
    run = 1'b1; ir_ready = 1'b1;
    step();
    run = 1'b0;
    repeat (3) step();
    ir_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (ir_valid !== 1'b1 || ir_pc !== 4'd2 || ir !== 16'h3681 || fetch_count !== 8'd3 ||
          rom_address !== 4'd3) begin
        errors++;
        $display("FAIL stall_%0d: v=%b pc=%0d ir=%h cnt=%0d addr=%0d, required 1 2 3681 3 3",
                 k, ir_valid, ir_pc, ir, fetch_count, rom_address);
      end
    end
    ir_ready = 1'b1;
    step();
    checks++;
    if (ir_valid !== 1'b1 || ir_pc !== 4'd3 || ir !== 16'hF600 || fetch_count !== 8'd4) begin
      errors++;
      $display("FAIL stall_resume: v=%b pc=%0d ir=%h cnt=%0d, required 1 3 f600 4",
               ir_valid, ir_pc, ir, fetch_count);
    end
  endtask

  // Self-jump at 5 halts; redirect to 0 restarts.
  task automatic test_halt();
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    rom[5] = 16'h8500;
    do_reset();
    run = 1'b1; ir_ready = 1'b1;
    step();
    run = 1'b0;
    repeat (5) step();
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (halted !== 1'b1 || ir_valid !== 1'b0 || rom_address !== 4'd5 || fetch_count !== 8'd5)
      begin
        errors++;
        $display("FAIL halt_%0d: h=%b v=%b addr=%0d cnt=%0d, required 1 0 5 5",
                 k, halted, ir_valid, rom_address, fetch_count);
      end
    end
    redirect_valid = 1'b1; redirect_target = 4'd0;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (halted !== 1'b0 || ir_valid !== 1'b0 || rom_address !== 4'd0) begin
      errors++;
      $display("FAIL halt_redirect: h=%b v=%b addr=%0d, required 0 0 0",
               halted, ir_valid, rom_address);
    end
    step();
    checks++;
    if (ir_valid !== 1'b1 || ir_pc !== 4'd0 || fetch_count !== 8'd6) begin
      errors++;
      $display("FAIL halt_restart: v=%b pc=%0d cnt=%0d, required 1 0 6",
               ir_valid, ir_pc, fetch_count);
    end
  endtask

  // Redirect wins over a folded jump and a stall in the same cycle.
  task automatic test_redirect();
    load_prog();
    do_reset();
    run = 1'b1; ir_ready = 1'b1;
    step();
    run = 1'b0;
    repeat (4) step();
    ir_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 4'd10;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (rom_address !== 4'd10 || ir_valid !== 1'b0 || fetch_count !== 8'd4) begin
      errors++;
      $display("FAIL redirect_prio: addr=%0d v=%b cnt=%0d, required 10 0 4",
               rom_address, ir_valid, fetch_count);
    end
    ir_ready = 1'b1;
    step();
    checks++;
    if (ir_valid !== 1'b1 || ir_pc !== 4'd10 || fetch_count !== 8'd5) begin
      errors++;
      $display("FAIL redirect_resume: v=%b pc=%0d cnt=%0d, required 1 10 5",
               ir_valid, ir_pc, fetch_count);
    end
  endtask

  // NOP stream: pc wraps 15->0, counter wraps after 256 issues.
  task automatic test_wrap();
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    do_reset();
    run = 1'b1; ir_ready = 1'b1;
    step();
    run = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      step();
      checks++;
      if (ir_valid !== 1'b1 || ir_pc !== 4'((k - 1) % 16) || fetch_count !== 8'(k % 256)) begin
        errors++;
        $display("FAIL wrap_%0d: v=%b pc=%0d cnt=%0d, required 1 %0d %0d",
                 k, ir_valid, ir_pc, fetch_count, (k - 1) % 16, k % 256);
      end
    end
  endtask

  // Asynchronous reset while stalled clears everything before the next edge.
  task automatic test_reset_mid();
    load_prog();
    do_reset();
    run = 1'b1; ir_ready = 1'b1;
    step();
    run = 1'b0;
    repeat (3) step();
    ir_ready = 1'b0;
    step();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({ir, ir_pc, ir_valid, halted, fetch_count, rom_address} !== '0) begin
      errors++;
      $display("FAIL reset_async: ir=%h ir_pc=%0d v=%b h=%b cnt=%0d addr=%0d, required all 0",
               ir, ir_pc, ir_valid, halted, fetch_count, rom_address);
    end
    step();
    rst_n = 1'b1; ir_ready = 1'b1;
    repeat (3) step();
    checks++;
    if (ir_valid !== 1'b0 || rom_address !== 4'd0 || fetch_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_idle: v=%b addr=%0d cnt=%0d, required 0 0 0",
               ir_valid, rom_address, fetch_count);
    end
    run = 1'b1;
    step();
    run = 1'b0;
    step();
    checks++;
    if (ir_valid !== 1'b1 || ir_pc !== 4'd0 || ir !== 16'hA601 || fetch_count !== 8'd1) begin
      errors++;
      $display("FAIL reset_restart: v=%b pc=%0d ir=%h cnt=%0d, required 1 0 a601 1",
               ir_valid, ir_pc, ir, fetch_count);
    end
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; ir_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    test_reset();
    test_sequence();
    test_stall();
    test_halt();
    test_redirect();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, program address width.
REQ-002 SHALL have parameter INST_W, default 16, instruction width.
REQ-003 SHALL have parameter CNT_W, default 8, fetch counter width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous and active-low.
REQ-006 run  input  1  start fetching; sampled only in IDLE.
REQ-007 rom_address  output  ADDR_W  program ROM address; equals pc combinationally.
REQ-008 rom_instruction  input  INST_W  combinational ROM data for rom_address.
REQ-009 ir  output  INST_W  issued instruction register.
REQ-010 ir_pc  output  ADDR_W  address ir was fetched from.
REQ-011 ir_valid  output  1  ir holds an instruction for decode.
REQ-012 ir_ready  input  1  decode accepts ir this cycle.
REQ-013 redirect_valid  input  1  taken-branch redirect from execute.
REQ-014 redirect_target  input  ADDR_W  redirect address.
REQ-015 halted  output  1  self-jump detected; fetch stopped.
REQ-016 fetch_count  output  CNT_W  instructions issued to ir since reset.

Function
REQ-017 SHALL implement states IDLE, RUN, HALT; state is not an output.
REQ-018 IDLE: pc, ir, ir_valid held; run=1 -> RUN next edge; redirect_valid ignored.
REQ-019 RUN: an "advance" occurs when ir_valid=0 or ir_ready=1.
REQ-020 Stall (ir_valid=1, ir_ready=0, no redirect): pc, ir, ir_pc, ir_valid, fetch_count held.
REQ-021 Advance, opcode rom_instruction[15:12] != 4'b1000: ir<=rom_instruction, ir_pc<=pc, ir_valid<=1, pc<=pc+1, fetch_count<=fetch_count+1.
REQ-022 Advance, opcode == 4'b1000 (jmp): jmp folded in fetch, not issued; pc<=rom_instruction[11:8], ir_valid<=0, fetch_count held.
REQ-023 Folded jmp with target == pc: state -> HALT, halted<=1, pc held, ir_valid<=0.
REQ-024 redirect_valid=1 in RUN or HALT: pc<=redirect_target, ir_valid<=0, state -> RUN, halted<=0; priority over stall, advance, and folded jmp the same cycle.
REQ-025 Redirect cycle: ir contents need not change, but ir_valid=0; the flushed ir is never counted again.
REQ-026 pc increment wraps modulo 2^ADDR_W (15 -> 0 at default).
REQ-027 fetch_count wraps modulo 2^CNT_W; no saturation.
REQ-028 HALT: ir_valid=0, pc constant, rom_address constant; exits only via redirect_valid or reset.
REQ-029 Latency: instruction at rom_address appears on ir one edge after the advancing cycle; sustained throughput one instruction/cycle with ir_ready=1 and no jmp.
REQ-030 Folded jmp costs exactly one bubble cycle (ir_valid=0 for one cycle).
REQ-031 ir_valid and ir SHALL change only on clk edges or reset; no combinational path from ir_ready to ir.

Reset
REQ-032 rst_n=0 asynchronously forces: state IDLE, pc=0, rom_address=0, ir=0, ir_pc=0, ir_valid=0, halted=0, fetch_count=0.
REQ-033 Reset mid-operation (any state, stalled or not) SHALL abandon in-flight ir with no partial update; after release, fetch resumes only after run=1.
REQ-034 Outputs SHALL be stable and defined from the first edge after rst_n deasserts.

Verification
REQ-035 ROM {0:A601,1:B401,2:3681,3:F600,4:8200}, run=1, ir_ready=1 -> ir_pc sequence 0,1,2,3,bubble,2,3,bubble,2...; fetch_count=4 after first bubble.
REQ-036 Same program, ir_ready=0 for 3 cycles while ir_pc=2 -> ir, ir_pc, fetch_count held 3 cycles; pc stays 3; resumes with ir_pc=3.
REQ-037 ROM word 5 = 8500, pc reaches 5 -> halted=1 next edge, ir_valid=0, rom_address=5 held; then redirect_valid=1, target=0 -> halted=0, next ir_pc=0.
REQ-038 redirect_valid=1 target=10 same cycle as a folded jmp to 2 and ir_ready=0 -> pc=10, ir_valid=0; jmp target ignored.
REQ-039 Straight-line NOP ROM (all 0000), ir_ready=1 -> ir_pc wraps 15 -> 0; after 256 issues fetch_count=0.
REQ-040 rst_n asserted mid-stream while stalled -> all outputs zero immediately (before next edge); held in IDLE until run=1.
